// File: rtl/ultrasonic_ranger_ctrl.sv
// HC-SR04-style ranging sequencer: trigger pulse, echo wait, echo width to cm
// conversion, and the mandatory re-trigger gap between measurements.
module ultrasonic_ranger_ctrl #(
  parameter int unsigned TRIG_CYCLES      = 350,
  parameter int unsigned CYCLES_PER_CM    = 2030,
  parameter int unsigned ECHO_WAIT_CYCLES = 35000,
  parameter int unsigned MAX_ECHO_CYCLES  = 1330000,
  parameter int unsigned GAP_CYCLES       = 2100000,
  parameter int unsigned DIST_W           = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              measure_en,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              dist_err
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned CM_W  = $clog2(CYCLES_PER_CM + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
  // The WAIT_ECHO cycle that sees echo_s rise is the first high cycle, so
  // MEASURE phase count N corresponds to high cycle N+2.
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(MAX_ECHO_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CM_W-1:0]  CM_LAST   = CM_W'(CYCLES_PER_CM - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CM_W-1:0]     cm_q, cm_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [DIST_W-1:0]   dist_cm_q, dist_cm_d;
  logic                dist_err_q, dist_err_d;
  logic                dist_valid_q, dist_valid_d;
  logic                trig_q;
  logic                echo_meta_q, echo_s_q;
  logic                count_echo;
  logic                timeout;

  always_comb begin
    state_d      = state_q;
    cm_d         = cm_q;
    acc_d        = acc_q;
    dist_cm_d    = dist_cm_q;
    dist_err_d   = dist_err_q;
    dist_valid_d = 1'b0;
    count_echo   = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      IDLE: begin
        if (measure_en) state_d = TRIG;
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (echo_s_q) begin
          state_d    = MEASURE;
          count_echo = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          timeout = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s_q) begin
          dist_cm_d    = acc_q;
          dist_err_d   = 1'b0;
          dist_valid_d = 1'b1;
          state_d      = GAP;
        end else if (cnt_q == ECHO_LAST) begin
          timeout = 1'b1;
        end else begin
          count_echo = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      dist_cm_d    = '1;
      dist_err_d   = 1'b1;
      dist_valid_d = 1'b1;
      state_d      = GAP;
    end

    // Whole centimetres only; the partial cm left in cm_q is discarded.
    if (count_echo) begin
      if (cm_q == CM_LAST) begin
        cm_d  = '0;
        acc_d = (acc_q == '1) ? acc_q : acc_q + 1'b1;
      end else begin
        cm_d = cm_q + 1'b1;
      end
    end

    if (state_d == TRIG && state_q != TRIG) begin
      cm_d  = '0;
      acc_d = '0;
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cm_q         <= '0;
      acc_q        <= '0;
      dist_cm_q    <= '0;
      dist_err_q   <= 1'b0;
      dist_valid_q <= 1'b0;
      trig_q       <= 1'b0;
      echo_meta_q  <= 1'b0;
      echo_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cm_q         <= cm_d;
      acc_q        <= acc_d;
      dist_cm_q    <= dist_cm_d;
      dist_err_q   <= dist_err_d;
      dist_valid_q <= dist_valid_d;
      trig_q       <= (state_d == TRIG);
      echo_meta_q  <= echo;
      echo_s_q     <= echo_meta_q;
    end
  end

  assign trig       = trig_q;
  assign busy       = (state_q != IDLE);
  assign dist_cm    = dist_cm_q;
  assign dist_valid = dist_valid_q;
  assign dist_err   = dist_err_q;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl with small timing parameters;
// a second instance with a long echo limit covers distance saturation.
module tb_ultrasonic_ranger_ctrl;

  logic       clk = 1'b0;
  logic       rst, measure_en, echo, measure_en2, echo2;
  logic       trig, busy, dist_valid, dist_err;
  logic [5:0] dist_cm;
  logic       trig2, busy2, dist_valid2, dist_err2;
  logic [5:0] dist_cm2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger_ctrl #(
    .TRIG_CYCLES(4), .CYCLES_PER_CM(10), .ECHO_WAIT_CYCLES(20),
    .MAX_ECHO_CYCLES(200), .GAP_CYCLES(8), .DIST_W(6)
  ) dut (
    .clk(clk), .rst(rst), .measure_en(measure_en), .echo(echo),
    .trig(trig), .busy(busy), .dist_cm(dist_cm),
    .dist_valid(dist_valid), .dist_err(dist_err)
  );

  ultrasonic_ranger_ctrl #(
    .TRIG_CYCLES(4), .CYCLES_PER_CM(10), .ECHO_WAIT_CYCLES(20),
    .MAX_ECHO_CYCLES(2000), .GAP_CYCLES(8), .DIST_W(6)
  ) dut_sat (
    .clk(clk), .rst(rst), .measure_en(measure_en2), .echo(echo2),
    .trig(trig2), .busy(busy2), .dist_cm(dist_cm2),
    .dist_valid(dist_valid2), .dist_err(dist_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance k cycles, counting dist_valid pulses from the main instance.
  task automatic tick_mon(input int k, output int pulses);
    pulses = 0;
    repeat (k) begin
      tick();
      if (dist_valid) pulses++;
    end
  endtask

  // Bounded wait for trig; n is the number of cycles taken (40 = gave up).
  task automatic wait_trig(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!trig && n < 40);
  endtask

  int p, p2, p3, n, trig_seen;

  initial begin
    rst = 1'b1; measure_en = 1'b0; echo = 1'b0;
    measure_en2 = 1'b0; echo2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_dist_cm", dist_cm, 0);
    check("rst_valid", dist_valid, 0);
    check("rst_err", dist_err, 0);

    // Trigger pulse: four cycles high, starting on the edge that samples measure_en.
    measure_en = 1'b1;
    tick();
    check("c1_trig_rise", trig, 1);
    check("c1_busy", busy, 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("c1_trig_hold", trig, 1);
    end
    tick();
    check("c1_trig_fall", trig, 0);
    check("c1_busy_wait", busy, 1);

    // 57-cycle echo, 5 cycles after trig falls.
    tick_mon(5, p);
    echo = 1'b1;
    tick_mon(57, p2);
    echo = 1'b0;
    tick_mon(2, p3);
    check("c2_early_pulse", p + p2 + p3, 0);
    tick();
    check("c2_valid", dist_valid, 1);
    check("c2_dist", dist_cm, 5);
    check("c2_err", dist_err, 0);
    tick();
    check("c2_valid_one_cycle", dist_valid, 0);
    check("c2_dist_held", dist_cm, 5);
    wait_trig(n);
    check("c2_gap_to_trig", n, 8);

    // No echo at all: wait timeout.
    tick_mon(4, p);
    check("c3_trig_fall", trig, 0);
    tick_mon(19, p2);
    check("c3_early_pulse", p + p2, 0);
    tick();
    check("c3_valid", dist_valid, 1);
    check("c3_dist", dist_cm, 63);
    check("c3_err", dist_err, 1);
    wait_trig(n);
    check("c3_gap_to_trig", n, 9);

    // Echo stuck high 300 cycles: timeout on the 200th synced high cycle.
    tick();
    tick();
    tick();
    tick();
    echo = 1'b1;
    tick_mon(50, p);
    measure_en = 1'b0;
    tick_mon(151, p2);
    check("c4_early_pulse", p + p2, 0);
    tick();
    check("c4_valid", dist_valid, 1);
    check("c4_dist", dist_cm, 63);
    check("c4_err", dist_err, 1);
    tick_mon(98, p);
    echo = 1'b0;
    tick_mon(20, p2);
    check("c4_second_pulse", p + p2, 0);
    check("c4_idle_busy", busy, 0);
    check("c4_idle_trig", trig, 0);

    // measure_en dropped mid-MEASURE: result still delivered, then rest in IDLE.
    measure_en = 1'b1;
    tick();
    check("c6a_trig", trig, 1);
    repeat (4) tick();
    echo = 1'b1;
    repeat (10) tick();
    measure_en = 1'b0;
    repeat (15) tick();
    echo = 1'b0;
    tick_mon(2, p);
    check("c6a_early_pulse", p, 0);
    tick();
    check("c6a_valid", dist_valid, 1);
    check("c6a_dist", dist_cm, 2);
    check("c6a_err", dist_err, 0);
    repeat (7) tick();
    check("c6a_busy_gap", busy, 1);
    tick();
    check("c6a_busy_idle", busy, 0);
    trig_seen = 0;
    repeat (20) begin
      tick();
      if (trig) trig_seen++;
    end
    check("c6a_no_retrig", trig_seen, 0);

    // Reset during TRIG.
    measure_en = 1'b1;
    tick();
    check("c6b_trig", trig, 1);
    tick();
    rst = 1'b1;
    tick();
    check("c6b_trig", trig, 0);
    check("c6b_busy", busy, 0);
    check("c6b_dist", dist_cm, 0);
    check("c6b_valid", dist_valid, 0);
    check("c6b_err", dist_err, 0);
    rst = 1'b0;
    measure_en = 1'b0;
    tick();

    // 1000-cycle echo with a 2000-cycle limit: distance saturates.
    measure_en2 = 1'b1;
    tick();
    check("c5_trig", trig2, 1);
    measure_en2 = 1'b0;
    repeat (4) tick();
    check("c5_trig_fall", trig2, 0);
    echo2 = 1'b1;
    p = 0;
    repeat (1000) begin
      tick();
      if (dist_valid2) p++;
    end
    echo2 = 1'b0;
    repeat (2) begin
      tick();
      if (dist_valid2) p++;
    end
    check("c5_early_pulse", p, 0);
    tick();
    check("c5_valid", dist_valid2, 1);
    check("c5_dist", dist_cm2, 63);
    check("c5_err", dist_err2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
